pit_control_logic: RTL and testbench

Bus-interface and configuration controller for the three 16-bit counters of the 8254-compatible timer.
- Decodes CPU accesses (cs_n/rd_n/wr_n/addr/data), holds each counter's 6-bit control field, and assembles 1- or 2-byte count values into load strobes.
- Executes counter-latch and read-back commands.
- Owns the LSB/MSB byte sequencing, the count/status latches and the null-count flags, so the counters only count.

---
 rtl/pit_control_logic.sv | 224 ++++++++++++++++++++++
 tb/tb_pit_control_logic.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pit_control_logic.sv
// Bus decode and configuration controller for the three 8254-style counters:
// control words, count assembly, counter/status latching and read-back.
module pit_control_logic #(
   parameter int unsigned NUM_CNT = 3,
   parameter int unsigned CW_W    = 6
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cs_n,
   input  logic                      rd_n,
   input  logic                      wr_n,
   input  logic [1:0]                addr,
   input  logic [7:0]                din,
   output logic [7:0]                dout,
   output logic                      dout_oe,
   input  logic [16*NUM_CNT-1:0]     cnt_value,
   input  logic [NUM_CNT-1:0]        cnt_out,
   input  logic [NUM_CNT-1:0]        cnt_loaded,
   output logic [CW_W*NUM_CNT-1:0]   cfg,
   output logic [NUM_CNT-1:0]        cfg_wr,
   output logic [15:0]               cr_data,
   output logic [NUM_CNT-1:0]        cr_load
);

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned BYTE_W = 8;
   localparam logic [1:0]  CTRL_ADDR = 2'd3;
   localparam logic [1:0]  RW_NONE   = 2'b00;
   localparam logic [1:0]  RW_LSB    = 2'b01;
   localparam logic [1:0]  RW_MSB    = 2'b10;
   localparam logic [1:0]  RW_BOTH   = 2'b11;

   logic                cs_n_q;
   logic                rd_n_q;
   logic                wr_n_q;
   logic                bad_q;
   logic [1:0]          wr_addr_q;
   logic [1:0]          rd_addr_q;
   logic [BYTE_W-1:0]   din_q;

   logic [NUM_CNT-1:0]  wr_msb;
   logic [NUM_CNT-1:0]  rd_msb;
   logic [NUM_CNT-1:0]  cl_valid;
   logic [NUM_CNT-1:0]  sl_valid;
   logic [NUM_CNT-1:0]  null_count;
   logic [BYTE_W-1:0]   lsb_byte [NUM_CNT];
   logic [CNT_W-1:0]    cl_data  [NUM_CNT];
   logic [BYTE_W-1:0]   sl_data  [NUM_CNT];

   logic                wr_commit_c;
   logic                rd_commit_c;
   logic                rd_en_c;
   logic [1:0]          rd_rw_c;
   logic                rd_sel_msb_c;
   logic [CNT_W-1:0]    rd_src_c;
   logic [BYTE_W-1:0]   rd_byte_c;
   logic [2:0]          rb_sel_c;

   // Access commit on the trailing edge of a strobe; a cycle with both strobes low poisons the access
   always_comb begin
      wr_commit_c = ~wr_n_q & wr_n & ~cs_n_q & ~bad_q;
      rd_commit_c = ~rd_n_q & rd_n & ~cs_n_q & ~bad_q;
      rb_sel_c    = din_q[3:1];
   end

   // Read byte selection: status latch, then count latch, then live count
   always_comb begin
      rd_en_c      = ~cs_n & ~rd_n & (addr != CTRL_ADDR);
      rd_rw_c      = RW_NONE;
      rd_sel_msb_c = 1'b0;
      rd_src_c     = '0;
      rd_byte_c    = '0;
      for (int i = 0; i < NUM_CNT; i++) begin
         if (addr == 2'(i)) begin
            rd_rw_c      = cfg[i*CW_W+4 +: 2];
            rd_src_c     = cl_valid[i] ? cl_data[i] : cnt_value[i*CNT_W +: CNT_W];
            rd_sel_msb_c = (rd_rw_c == RW_MSB) | ((rd_rw_c == RW_BOTH) & rd_msb[i]);
            if (sl_valid[i])
               rd_byte_c = sl_data[i];
            else
               rd_byte_c = rd_sel_msb_c ? rd_src_c[15:8] : rd_src_c[7:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cs_n_q     <= 1'b1;
         rd_n_q     <= 1'b1;
         wr_n_q     <= 1'b1;
         bad_q      <= 1'b0;
         wr_addr_q  <= '0;
         rd_addr_q  <= '0;
         din_q      <= '0;
         wr_msb     <= '0;
         rd_msb     <= '0;
         cl_valid   <= '0;
         sl_valid   <= '0;
         null_count <= '1;
         cfg        <= '0;
         cfg_wr     <= '0;
         cr_data    <= '0;
         cr_load    <= '0;
         dout       <= '0;
         dout_oe    <= 1'b0;
         for (int i = 0; i < NUM_CNT; i++) begin
            lsb_byte[i] <= '0;
            cl_data[i]  <= '0;
            sl_data[i]  <= '0;
         end
      end else begin
         cs_n_q  <= cs_n;
         rd_n_q  <= rd_n;
         wr_n_q  <= wr_n;
         bad_q   <= (~rd_n & ~wr_n) | (bad_q & ~(rd_n & wr_n));
         if (!wr_n) begin
            wr_addr_q <= addr;
            din_q     <= din;
         end
         if (!rd_n)
            rd_addr_q <= addr;

         dout    <= rd_en_c ? rd_byte_c : 8'h00;
         dout_oe <= rd_en_c;
         cfg_wr  <= '0;
         cr_load <= '0;

         // Null count follows the load handshake; a new load request wins over a transfer
         for (int i = 0; i < NUM_CNT; i++) begin
            if (cr_load[i])
               null_count[i] <= 1'b1;
            else if (cnt_loaded[i])
               null_count[i] <= 1'b0;
         end

         if (wr_commit_c && wr_addr_q == CTRL_ADDR) begin
            if (din_q[7:6] == 2'd3) begin
               for (int i = 0; i < NUM_CNT; i++) begin
                  if (rb_sel_c[i]) begin
                     if (!din_q[5] && !cl_valid[i]) begin
                        cl_data[i]  <= cnt_value[i*CNT_W +: CNT_W];
                        cl_valid[i] <= 1'b1;
                     end
                     if (!din_q[4] && !sl_valid[i]) begin
                        sl_data[i]  <= {cnt_out[i], null_count[i], cfg[i*CW_W +: CW_W]};
                        sl_valid[i] <= 1'b1;
                     end
                  end
               end
            end else begin
               for (int i = 0; i < NUM_CNT; i++) begin
                  if (din_q[7:6] == 2'(i)) begin
                     if (din_q[5:4] == RW_NONE) begin
                        if (!cl_valid[i]) begin
                           cl_data[i]  <= cnt_value[i*CNT_W +: CNT_W];
                           cl_valid[i] <= 1'b1;
                        end
                     end else begin
                        cfg[i*CW_W +: CW_W] <= din_q[CW_W-1:0];
                        wr_msb[i]     <= 1'b0;
                        rd_msb[i]     <= 1'b0;
                        cl_valid[i]   <= 1'b0;
                        sl_valid[i]   <= 1'b0;
                        null_count[i] <= 1'b1;
                        cfg_wr[i]     <= 1'b1;
                     end
                  end
               end
            end
         end

         // Count byte assembly into a load strobe
         if (wr_commit_c && wr_addr_q != CTRL_ADDR) begin
            for (int i = 0; i < NUM_CNT; i++) begin
               if (wr_addr_q == 2'(i)) begin
                  case (cfg[i*CW_W+4 +: 2])
                     RW_LSB: begin
                        cr_data    <= {8'h00, din_q};
                        cr_load[i] <= 1'b1;
                     end
                     RW_MSB: begin
                        cr_data    <= {din_q, 8'h00};
                        cr_load[i] <= 1'b1;
                     end
                     RW_BOTH: begin
                        if (!wr_msb[i]) begin
                           lsb_byte[i] <= din_q;
                           wr_msb[i]   <= 1'b1;
                        end else begin
                           cr_data    <= {din_q, lsb_byte[i]};
                           cr_load[i] <= 1'b1;
                           wr_msb[i]  <= 1'b0;
                        end
                     end
                     default: ;
                  endcase
               end
            end
         end

         // Read commit: status first, otherwise advance byte sequence and release count latch
         if (rd_commit_c && rd_addr_q != CTRL_ADDR) begin
            for (int i = 0; i < NUM_CNT; i++) begin
               if (rd_addr_q == 2'(i)) begin
                  if (sl_valid[i]) begin
                     sl_valid[i] <= 1'b0;
                  end else begin
                     case (cfg[i*CW_W+4 +: 2])
                        RW_LSB, RW_MSB: cl_valid[i] <= 1'b0;
                        RW_BOTH: begin
                           rd_msb[i] <= ~rd_msb[i];
                           if (rd_msb[i])
                              cl_valid[i] <= 1'b0;
                        end
                        default: ;
                     endcase
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_pit_control_logic.sv
// Directed self-checking bench for pit_control_logic with hand-computed expectations.
module tb_pit_control_logic;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cs_n;
   logic        rd_n;
   logic        wr_n;
   logic [1:0]  addr;
   logic [7:0]  din;
   logic [7:0]  dout;
   logic        dout_oe;
   logic [47:0] cnt_value;
   logic [2:0]  cnt_out;
   logic [2:0]  cnt_loaded;
   logic [17:0] cfg;
   logic [2:0]  cfg_wr;
   logic [15:0] cr_data;
   logic [2:0]  cr_load;

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] rdat;

   pit_control_logic dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cs_n       (cs_n),
      .rd_n       (rd_n),
      .wr_n       (wr_n),
      .addr       (addr),
      .din        (din),
      .dout       (dout),
      .dout_oe    (dout_oe),
      .cnt_value  (cnt_value),
      .cnt_out    (cnt_out),
      .cnt_loaded (cnt_loaded),
      .cfg        (cfg),
      .cfg_wr     (cfg_wr),
      .cr_data    (cr_data),
      .cr_load    (cr_load)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Full write cycle; returns right after the commit edge so strobes are visible
   task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
      cs_n = 1'b0; addr = a; din = d; wr_n = 1'b0;
      tick();
      wr_n = 1'b1;
      tick();
      cs_n = 1'b1;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [7:0] d, input logic [0:0] exp_oe);
      cs_n = 1'b0; addr = a; rd_n = 1'b0;
      tick();
      d = dout;
      check("dout_oe", 32'(dout_oe), 32'(exp_oe));
      rd_n = 1'b1;
      tick();
      cs_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; addr = 2'd0; din = 8'h00;
      cnt_value = '0; cnt_out = '0; cnt_loaded = '0;
      tick(); tick(); tick();
      rst_n = 1'b1;
      tick();

      // Reset state
      check("rst_cfg", 32'(cfg), 32'h0);
      check("rst_cfg_wr", 32'(cfg_wr), 32'h0);
      check("rst_cr_load", 32'(cr_load), 32'h0);
      check("rst_cr_data", 32'(cr_data), 32'h0);
      check("rst_dout", 32'(dout), 32'h0);
      check("rst_dout_oe", 32'(dout_oe), 32'h0);
      bus_write(2'd3, 8'hE2);
      bus_read(2'd0, rdat, 1'b1);
      check("rst_status_c0", 32'(rdat), 32'h40);

      // Counter 0: RW=11 mode 2, two-byte load
      bus_write(2'd3, 8'h34);
      check("cfg_wr_c0", 32'(cfg_wr), 32'h1);
      check("cfg_c0", 32'(cfg), 32'h00034);
      tick();
      check("cfg_wr_c0_end", 32'(cfg_wr), 32'h0);
      bus_write(2'd0, 8'h34);
      check("c0_lsb_noload", 32'(cr_load), 32'h0);
      bus_write(2'd0, 8'h12);
      check("c0_load", 32'(cr_load), 32'h1);
      check("c0_cr_data", 32'(cr_data), 32'h1234);
      tick();
      check("c0_load_end", 32'(cr_load), 32'h0);
      cnt_loaded = 3'b001;
      tick();
      cnt_loaded = 3'b000;
      bus_write(2'd3, 8'hE2);
      bus_read(2'd0, rdat, 1'b1);
      check("c0_status_null0", 32'(rdat), 32'h34);

      // Counter latch command on c0
      cnt_value[15:0] = 16'hABCD;
      bus_write(2'd3, 8'h00);
      cnt_value[15:0] = 16'h0001;
      bus_read(2'd0, rdat, 1'b1);
      check("latch_lsb", 32'(rdat), 32'hCD);
      bus_read(2'd0, rdat, 1'b1);
      check("latch_msb", 32'(rdat), 32'hAB);
      bus_read(2'd0, rdat, 1'b1);
      check("live_lsb", 32'(rdat), 32'h01);
      bus_read(2'd0, rdat, 1'b1);
      check("live_msb", 32'(rdat), 32'h00);
      cnt_value[15:0] = 16'hABCD;
      bus_write(2'd3, 8'h00);
      cnt_value[15:0] = 16'h0001;
      bus_write(2'd3, 8'h00);
      bus_read(2'd0, rdat, 1'b1);
      check("relatch_lsb", 32'(rdat), 32'hCD);
      bus_read(2'd0, rdat, 1'b1);
      check("relatch_msb", 32'(rdat), 32'hAB);

      // Counter 1: RW=01 mode 5, read-back count+status
      bus_write(2'd3, 8'h5A);
      check("cfg_wr_c1", 32'(cfg_wr), 32'h2);
      check("cfg_c1", 32'(cfg), 32'h006B4);
      bus_write(2'd1, 8'h55);
      check("c1_load", 32'(cr_load), 32'h2);
      check("c1_cr_data", 32'(cr_data), 32'h0055);
      tick();
      cnt_loaded = 3'b010;
      tick();
      cnt_loaded = 3'b000;
      cnt_out = 3'b010;
      cnt_value[31:16] = 16'h0055;
      bus_write(2'd3, 8'hC4);
      cnt_value[31:16] = 16'h0066;
      bus_read(2'd1, rdat, 1'b1);
      check("rb_status_c1", 32'(rdat), 32'h9A);
      bus_read(2'd1, rdat, 1'b1);
      check("rb_count_c1", 32'(rdat), 32'h55);
      bus_read(2'd1, rdat, 1'b1);
      check("c1_live_after", 32'(rdat), 32'h66);

      // Control register read returns zero, no enable
      bus_read(2'd3, rdat, 1'b0);
      check("ctrl_read", 32'(rdat), 32'h00);

      // Counter 2: cfg write cancels half-finished two-byte write
      bus_write(2'd3, 8'hB0);
      check("cfg_wr_c2", 32'(cfg_wr), 32'h4);
      bus_write(2'd2, 8'h10);
      check("c2_lsb_noload", 32'(cr_load), 32'h0);
      bus_write(2'd3, 8'hB0);
      bus_write(2'd2, 8'h22);
      check("c2_restart_noload", 32'(cr_load), 32'h0);
      bus_write(2'd2, 8'h33);
      check("c2_load", 32'(cr_load), 32'h4);
      check("c2_cr_data", 32'(cr_data), 32'h3322);

      // Illegal access: both strobes low
      cs_n = 1'b0; addr = 2'd2; din = 8'h44; wr_n = 1'b0; rd_n = 1'b0;
      tick();
      wr_n = 1'b1; rd_n = 1'b1;
      tick();
      check("illegal_noload", 32'(cr_load), 32'h0);
      tick();
      check("illegal_nocfgwr", 32'(cfg_wr), 32'h0);
      cs_n = 1'b1;
      bus_write(2'd2, 8'h55);
      check("post_illegal_lsb", 32'(cr_load), 32'h0);
      bus_write(2'd2, 8'h66);
      check("post_illegal_load", 32'(cr_load), 32'h4);
      check("post_illegal_data", 32'(cr_data), 32'h6655);

      // Reset between LSB and MSB writes
      bus_write(2'd0, 8'h77);
      check("pre_rst_lsb", 32'(cr_load), 32'h0);
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      check("mid_rst_cfg", 32'(cfg), 32'h0);
      check("mid_rst_cr_load", 32'(cr_load), 32'h0);
      check("mid_rst_cr_data", 32'(cr_data), 32'h0);
      bus_write(2'd0, 8'h88);
      check("unconfig_write", 32'(cr_load), 32'h0);
      bus_write(2'd3, 8'h30);
      bus_write(2'd0, 8'h11);
      check("after_rst_lsb", 32'(cr_load), 32'h0);
      bus_write(2'd0, 8'h22);
      check("after_rst_load", 32'(cr_load), 32'h1);
      check("after_rst_data", 32'(cr_data), 32'h2211);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
